// File: rtl/approx_dot_acc_if.sv
// Operand-in / sum-out stream bundle for approx_dot_acc.
// master = producer/consumer side, slave = the accumulator.
`timescale 1ns/1ps
interface approx_dot_acc_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/approx_dot_acc.sv
// Streaming dot-product accumulator around an external 8x8 multiplier.
// Optional DOT_ACC_SAT_EN: saturate on overflow and raise out_ovf.
`timescale 1ns/1ps
module approx_dot_acc #(
  parameter int LEN   = 16,
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  approx_dot_acc_if.slave io,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_prod
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       mul_a_q;
  logic [7:0]       mul_b_q;
  logic             s1_v_q;
  logic             s1_first_q;
  logic             s1_last_q;
  logic [15:0]      prod_q;
  logic             s2_v_q;
  logic             s2_first_q;
  logic             s2_last_q;
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             hs;
  logic             first_in;
  logic             last_in;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] prod_x;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;

  assign io.in_ready  = (state_q == ACC);
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = sum_q;
  assign io.out_ovf   = ovf_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

  assign hs       = io.in_valid & io.in_ready;
  assign first_in = (cnt_q == '0);
  assign last_in  = (cnt_q == CW'(LEN - 1));

  // The accumulator doubles as the output register.
`ifdef DOT_ACC_SAT_EN
  logic [ACC_W:0] sum_w;

  always_comb begin
    base   = s2_first_q ? '0 : sum_q;
    prod_x = ACC_W'(prod_q);
    sum_w  = {1'b0, base} + {1'b0, prod_x};
    acc_d  = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    ovf_d  = (~s2_first_q & ovf_q) | sum_w[ACC_W];
  end
`else
  always_comb begin
    base   = s2_first_q ? '0 : sum_q;
    prod_x = ACC_W'(prod_q);
    acc_d  = base + prod_x;
    ovf_d  = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_v_q <= hs;
      if (hs) begin
        mul_a_q    <= io.in_a;
        mul_b_q    <= io.in_b;
        s1_first_q <= first_in;
        s1_last_q  <= last_in;
        cnt_q      <= last_in ? '0 : cnt_q + 1'b1;
      end

      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        prod_q     <= mul_prod;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end

      if (s2_v_q) begin
        sum_q <= acc_d;
        ovf_q <= ovf_d;
      end

      unique case (state_q)
        ACC: begin
          if (hs && last_in) state_q <= DRAIN;
        end
        DRAIN: begin
          if (s2_v_q && s2_last_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (io.out_ready) begin
            state_q     <= ACC;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_dot_acc.sv
// Directed bench for approx_dot_acc: three instances (LEN 4/2/1)
// share stimulus; sel picks which one is observed.
`timescale 1ns/1ps
module tb_approx_dot_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  approx_dot_acc_if #(.ACC_W(24)) if4 ();
  approx_dot_acc_if #(.ACC_W(16)) if2 ();
  approx_dot_acc_if #(.ACC_W(24)) if1 ();

  assign if4.in_valid  = in_valid;
  assign if4.in_a      = in_a;
  assign if4.in_b      = in_b;
  assign if4.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_a      = in_a;
  assign if2.in_b      = in_b;
  assign if2.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_a      = in_a;
  assign if1.in_b      = in_b;
  assign if1.out_ready = out_ready;

  logic [7:0]  ma4, mb4, ma2, mb2, ma1, mb1;
  logic [15:0] p4, p2, p1;

  assign p4 = 16'(ma4) * 16'(mb4);
  assign p2 = 16'(ma2) * 16'(mb2);
  assign p1 = 16'(ma1) * 16'(mb1);

  approx_dot_acc #(.LEN(4), .ACC_W(24)) u4 (
    .clk(clk), .rst_n(rst_n), .io(if4.slave),
    .mul_a(ma4), .mul_b(mb4), .mul_prod(p4)
  );
  approx_dot_acc #(.LEN(2), .ACC_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .io(if2.slave),
    .mul_a(ma2), .mul_b(mb2), .mul_prod(p2)
  );
  approx_dot_acc #(.LEN(1), .ACC_W(24)) u1 (
    .clk(clk), .rst_n(rst_n), .io(if1.slave),
    .mul_a(ma1), .mul_b(mb1), .mul_prod(p1)
  );

  logic        o_rdy;
  logic        o_vld;
  logic [23:0] o_sum;
  logic        o_ovf;

  always_comb begin
    o_rdy = if4.in_ready;
    o_vld = if4.out_valid;
    o_sum = if4.out_sum;
    o_ovf = if4.out_ovf;
    if (sel == 1) begin
      o_rdy = if2.in_ready;
      o_vld = if2.out_valid;
      o_sum = 24'(if2.out_sum);
      o_ovf = if2.out_ovf;
    end else if (sel == 2) begin
      o_rdy = if1.in_ready;
      o_vld = if1.out_valid;
      o_sum = if1.out_sum;
      o_ovf = if1.out_ovf;
    end
  end

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one pair at a negedge; returns at the negedge after the handshake.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!o_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!o_rdy) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", o_rdy);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!o_vld && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!o_vld) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%0b required 1", o_vld);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    apply_reset();
    checks += 5;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %0b required 1", o_rdy);
    end
    if (o_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %0b required 0", o_vld);
    end
    if (o_sum !== 24'd0) begin
      errors++;
      $display("FAIL rst_out_sum: got %0d required 0", o_sum);
    end
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_ovf: got %0b required 0", o_ovf);
    end
    if (ma4 !== 8'd0 || mb4 !== 8'd0) begin
      errors++;
      $display("FAIL rst_mul_ab: got %0d,%0d required 0,0", ma4, mb4);
    end
  endtask

  task automatic test_basic();
    int cyc;
    sel = 0;
    apply_reset();
    send(8'd3, 8'd5);
    send(8'd10, 8'd10);
    send(8'd255, 8'd255);
    send(8'd0, 8'd7);
    wait_out(cyc);
    checks += 3;
    if (cyc != 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 2", cyc);
    end
    if (o_sum !== 24'd65140) begin
      errors++;
      $display("FAIL basic_sum: got %0d required 65140", o_sum);
    end
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf: got %0b required 0", o_ovf);
    end
    accept();
  endtask

  task automatic test_saturation();
    int cyc;
    logic [23:0] exp_sum;
    logic        exp_ovf;
`ifdef DOT_ACC_SAT_EN
    exp_sum = 24'd65535;
    exp_ovf = 1'b1;
`else
    exp_sum = 24'd64514;
    exp_ovf = 1'b0;
`endif
    sel = 1;
    apply_reset();
    send(8'd255, 8'd255);
    send(8'd255, 8'd255);
    wait_out(cyc);
    checks += 2;
    if (o_sum !== exp_sum) begin
      errors++;
      $display("FAIL sat_sum: got %0d required %0d", o_sum, exp_sum);
    end
    if (o_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL sat_ovf: got %0b required %0b", o_ovf, exp_ovf);
    end
    accept();
    checks++;
    if (o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_clear: got %0b required 0", o_ovf);
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    sel = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) send(8'd2, 8'd2);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_vld !== 1'b1 || o_sum !== 24'd16 || o_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable[%0d]: valid=%0b sum=%0d ready=%0b required 1,16,0",
                 i, o_vld, o_sum, o_rdy);
      end
      @(negedge clk);
    end
    accept();
    checks += 2;
    if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%0b valid=%0b required 1,0", o_rdy, o_vld);
    end
    if (o_sum !== 24'd16) begin
      errors++;
      $display("FAIL bp_sum_kept: got %0d required 16", o_sum);
    end
  endtask

  task automatic test_bubbles();
    int cyc;
    sel = 0;
    apply_reset();
    send(8'd1, 8'd2);
    @(negedge clk);
    send(8'd3, 8'd4);
    @(negedge clk);
    send(8'd5, 8'd6);
    @(negedge clk);
    send(8'd7, 8'd8);
    wait_out(cyc);
    checks++;
    if (o_sum !== 24'd100) begin
      errors++;
      $display("FAIL bubbles_sum: got %0d required 100", o_sum);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    int nv;
    sel = 0;
    apply_reset();
    send(8'd9, 8'd9);
    send(8'd9, 8'd9);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    checks++;
    if (o_vld !== 1'b0 || o_sum !== 24'd0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%0b sum=%0d required 0,0", o_vld, o_sum);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(8'd1, 8'd1);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_vld) begin
        nv++;
        checks++;
        if (o_sum !== 24'd4) begin
          errors++;
          $display("FAIL midrst_sum: got %0d required 4", o_sum);
        end
        accept();
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d outputs required 1", nv);
    end
  endtask

  task automatic test_len1();
    int cyc;
    sel = 2;
    apply_reset();
    send(8'd2, 8'd3);
    wait_out(cyc);
    checks += 2;
    if (o_sum !== 24'd6) begin
      errors++;
      $display("FAIL len1_sum0: got %0d required 6", o_sum);
    end
    if (cyc != 2) begin
      errors++;
      $display("FAIL len1_latency: got %0d cycles required 2", cyc);
    end
    accept();
    send(8'd4, 8'd5);
    wait_out(cyc);
    checks++;
    if (o_sum !== 24'd20) begin
      errors++;
      $display("FAIL len1_sum1: got %0d required 20", o_sum);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_pressure();
    test_bubbles();
    test_reset_mid();
    test_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
